// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone bus arbiter: FSM state encoding and
// the default master slot assignment (icache, dcache, LSU).
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    localparam int MST_ICACHE = 0;
    localparam int MST_DCACHE = 1;
    localparam int MST_LSU    = 2;

endpackage

// File: rtl/wb_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ...
// modulo N; returns the winner one-hot and as an index.
module rr_picker #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IDX_W = $clog2(N);

    // Scan from the farthest candidate back to ptr so the closest requester wins last
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int cand;
            cand = (int'(ptr) + k) % N;
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end else begin
                gnt = gnt;
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave port between N masters;
// the grant is held for the whole bus cycle. Optional watchdog: WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                            clk,
    input  logic                            rstn_i,
    input  logic [N_MASTERS-1:0]            m_cyc_i,
    input  logic [N_MASTERS-1:0]            m_stb_i,
    input  logic [N_MASTERS-1:0]            m_we_i,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_sel_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_adr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_dat_i,
    output logic [DATA_W-1:0]               m_dat_o,
    output logic [N_MASTERS-1:0]            m_ack_o,
    output logic [N_MASTERS-1:0]            m_err_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_we_o,
    output logic [DATA_W/8-1:0]             s_sel_o,
    output logic [ADDR_W-1:0]               s_adr_o,
    output logic [DATA_W-1:0]               s_dat_o,
    input  logic [DATA_W-1:0]               s_dat_i,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    output logic [N_MASTERS-1:0]            gnt_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = $clog2(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT < 1) begin : g_param_check
        $error("wb_bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_e           state_r, state_nxt_s;
    logic [N_MASTERS-1:0] gnt_r, gnt_nxt_s, pick_gnt_s;
    logic [IDX_W-1:0]     idx_r, idx_nxt_s, pick_idx_s;
    logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_nxt_s, idx_inc_s;
    logic                 busy_s, owner_cyc_s, timeout_s, cyc_en_s;

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req (m_cyc_i),
        .ptr (rr_ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    assign busy_s      = (state_r == BUSY);
    assign owner_cyc_s = m_cyc_i[idx_r];
    assign idx_inc_s   = (idx_r == IDX_W'(N_MASTERS - 1)) ? '0 : idx_r + IDX_W'(1);
    assign cyc_en_s    = busy_s && owner_cyc_s && !timeout_s;
    assign gnt_o       = gnt_r;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_r;
    logic            stall_s;

    assign stall_s   = busy_s && owner_cyc_s && m_stb_i[idx_r] && !s_ack_i && !s_err_i;
    assign timeout_s = stall_s && (to_cnt_r == TO_W'(TIMEOUT - 1));

    // Watchdog: counts stalled strobe cycles of the owner, cleared on any response
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_r <= '0;
        end else if (!busy_s || s_ack_i || s_err_i || timeout_s) begin
            to_cnt_r <= '0;
        end else if (stall_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Arbitration state, current owner and round-robin pointer
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r  <= IDLE;
            gnt_r    <= '0;
            idx_r    <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_nxt_s;
            gnt_r    <= gnt_nxt_s;
            idx_r    <= idx_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Next-state: grant on any request, release once the owner drops cyc
    always_comb begin
        state_nxt_s  = state_r;
        gnt_nxt_s    = gnt_r;
        idx_nxt_s    = idx_r;
        rr_ptr_nxt_s = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_nxt_s = BUSY;
                    gnt_nxt_s   = pick_gnt_s;
                    idx_nxt_s   = pick_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (!owner_cyc_s) begin
                    state_nxt_s  = IDLE;
                    gnt_nxt_s    = '0;
                    idx_nxt_s    = '0;
                    rr_ptr_nxt_s = idx_inc_s;
                end else if (timeout_s) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            FLUSH: begin
                if (!owner_cyc_s) begin
                    state_nxt_s  = IDLE;
                    gnt_nxt_s    = '0;
                    idx_nxt_s    = '0;
                    rr_ptr_nxt_s = idx_inc_s;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
                gnt_nxt_s   = '0;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Slave-side mux from the owner and response routing back to it alone
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy_s) begin
            s_cyc_o        = cyc_en_s;
            s_stb_o        = cyc_en_s && m_stb_i[idx_r];
            s_we_o         = cyc_en_s && m_we_i[idx_r];
            s_sel_o        = m_sel_i[idx_r*SEL_W +: SEL_W];
            s_adr_o        = m_adr_i[idx_r*ADDR_W +: ADDR_W];
            s_dat_o        = m_dat_i[idx_r*DATA_W +: DATA_W];
            m_dat_o        = s_dat_i;
            m_ack_o[idx_r] = s_ack_i;
            m_err_o[idx_r] = s_err_i || timeout_s;
        end else begin
            s_cyc_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: vector table, corner-case sequences
// and randomized traffic compared against an owner/last-winner reference model.
module tb_wb_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk;
    logic              rstn;
    logic [N-1:0]      m_cyc, m_stb, m_we;
    logic [N*4-1:0]    m_sel;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [DW-1:0]     s_dat;
    logic              s_ack, s_err;
    logic [DW-1:0]     d_mdat, d_sdat;
    logic [N-1:0]      d_ack, d_err, d_gnt;
    logic              d_cyc, d_stb, d_we;
    logic [3:0]        d_sel;
    logic [AW-1:0]     d_adr;

    wb_bus_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn_i(rstn),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(d_mdat), .m_ack_o(d_ack),
        .m_err_o(d_err), .s_cyc_o(d_cyc), .s_stb_o(d_stb), .s_we_o(d_we),
        .s_sel_o(d_sel), .s_adr_o(d_adr), .s_dat_o(d_sdat), .s_dat_i(s_dat),
        .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(d_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, who won last, watchdog bookkeeping
    int owner, last, stall;
    bit flushing;

    typedef struct packed {
        logic        rst;
        logic [2:0]  cyc;
        logic        ack;
        logic [31:0] sdat;
        logic        e_scyc;
        logic [2:0]  e_ack;
        logic [31:0] e_mdat;
        logic [2:0]  e_gnt;
    } vec_t;

    vec_t tbl[$];

    task automatic expect_eq(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit timeout_due();
`ifdef WB_ARB_TIMEOUT_EN
        return m_cyc[owner] && m_stb[owner] && !s_ack && !s_err && (stall == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [111:0] model_expect();
        logic        e_cyc, e_stb, e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_adr, e_dat, e_md;
        logic [2:0]  e_ack, e_err, e_gnt;
        bit          live, to;
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = 4'h0;
        e_adr = 32'h0; e_dat = 32'h0; e_md = 32'h0;
        e_ack = 3'b000; e_err = 3'b000; e_gnt = 3'b000;
        live = rstn && (owner >= 0) && !flushing;
        to   = live && timeout_due();
        if (rstn && owner >= 0) e_gnt[owner] = 1'b1;
        if (live) begin
            e_cyc        = m_cyc[owner] && !to;
            e_stb        = e_cyc && m_stb[owner];
            e_we         = e_cyc && m_we[owner];
            e_sel        = m_sel[owner*4 +: 4];
            e_adr        = m_adr[owner*AW +: AW];
            e_dat        = m_dat[owner*DW +: DW];
            e_md         = s_dat;
            e_ack[owner] = s_ack;
            e_err[owner] = s_err || to;
        end
        return {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat, e_md, e_ack, e_err, e_gnt};
    endfunction

    task automatic model_step();
        if (!rstn) begin
            owner = -1; last = N - 1; stall = 0; flushing = 1'b0;
        end else if (owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (m_cyc[c] && owner < 0) owner = c;
            end
        end else if (!m_cyc[owner]) begin
            last = owner; owner = -1; flushing = 1'b0; stall = 0;
        end else if (!flushing) begin
            if (timeout_due()) begin
                flushing = 1'b1; stall = 0;
            end else if (s_ack || s_err) begin
                stall = 0;
            end else if (m_stb[owner]) begin
                stall++;
            end
        end
    endtask

    // Mid-cycle: compare every output against the model
    task automatic settle();
        @(negedge clk);
        expect_eq("model", {16'h0, d_cyc, d_stb, d_we, d_sel, d_adr, d_sdat, d_mdat, d_ack, d_err, d_gnt},
                  {16'h0, model_expect()});
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [2:0] cyc, logic [2:0] stb, logic ack);
        m_cyc = cyc; m_stb = stb; s_ack = ack;
    endtask

    initial begin
        rstn = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_sel = 12'hF0F;
        m_adr = {32'h0000_0300, 32'h0000_0100, 32'h0000_0200};
        m_dat = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
        owner = -1; last = N - 1; stall = 0; flushing = 1'b0;
        #1;
        expect_eq("reset_outputs", {d_cyc, d_stb, d_we, d_sel, d_adr, d_sdat, d_mdat, d_ack, d_err, d_gnt}, 128'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single read by master 1, then reset, then 3-way contention 0,1,2,0
        tbl.push_back(vec_t'{1'b0, 3'b010, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b010, 1'b0, 32'h0,        1'b1, 3'b000, 32'h0,        3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b010, 1'b0, 32'h0,        1'b1, 3'b000, 32'h0,        3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b010, 1'b1, 32'hDEADBEEF, 1'b1, 3'b010, 32'hDEADBEEF, 3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b000, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b000, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});
        tbl.push_back(vec_t'{1'b1, 3'b000, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b111, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b111, 1'b1, 32'hA0,       1'b1, 3'b001, 32'hA0,       3'b001});
        tbl.push_back(vec_t'{1'b0, 3'b110, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b001});
        tbl.push_back(vec_t'{1'b0, 3'b110, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b110, 1'b1, 32'hA1,       1'b1, 3'b010, 32'hA1,       3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b101, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b010});
        tbl.push_back(vec_t'{1'b0, 3'b101, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b101, 1'b1, 32'hA2,       1'b1, 3'b100, 32'hA2,       3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b001, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b100});
        tbl.push_back(vec_t'{1'b0, 3'b001, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});
        tbl.push_back(vec_t'{1'b0, 3'b001, 1'b1, 32'hA3,       1'b1, 3'b001, 32'hA3,       3'b001});
        tbl.push_back(vec_t'{1'b0, 3'b000, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b001});
        tbl.push_back(vec_t'{1'b0, 3'b000, 1'b0, 32'h0,        1'b0, 3'b000, 32'h0,        3'b000});

        for (int i = 0; i < tbl.size(); i++) begin
            rstn = !tbl[i].rst;
            drive(tbl[i].cyc, tbl[i].cyc, tbl[i].ack);
            s_dat = tbl[i].sdat;
            settle();
            expect_eq($sformatf("vec%0d", i), {88'h0, d_cyc, d_ack, d_mdat, d_gnt},
                      {88'h0, tbl[i].e_scyc, tbl[i].e_ack, tbl[i].e_mdat, tbl[i].e_gnt});
            advance();
        end
        rstn = 1'b1; s_dat = '0;

        // Burst lock: m1 holds cyc across 8 beats while m2 waits
        drive(3'b110, 3'b010, 1'b0);
        settle(); advance();
        for (int b = 0; b < 8; b++) begin
            drive(3'b110, 3'b010, 1'b1);
            s_dat = $urandom;
            settle();
            expect_eq("burst_ack", {122'h0, d_gnt, d_ack}, {122'h0, 3'b010, 3'b010});
            advance();
            drive(3'b110, 3'b000, 1'b0);
            settle();
            expect_eq("burst_hold", {125'h0, d_gnt}, {125'h0, 3'b010});
            advance();
        end
        drive(3'b100, 3'b100, 1'b0);
        settle(); advance();
        settle(); advance();
        settle();
        expect_eq("burst_next", {124'h0, d_gnt, d_cyc}, {124'h0, 3'b100, 1'b1});
        advance();

        // Abort: m2 drops cyc, slave acks one cycle late
        drive(3'b000, 3'b000, 1'b0);
        settle();
        expect_eq("abort_cyc", {127'h0, d_cyc}, 128'h0);
        advance();
        drive(3'b000, 3'b000, 1'b1);
        settle();
        expect_eq("abort_late_ack", {121'h0, d_ack, d_gnt, d_cyc}, 128'h0);
        advance();

        // Reset mid-transfer, then a 3-way tie must go to m0
        drive(3'b010, 3'b010, 1'b0);
        settle(); advance();
        settle();
        advance();
        rstn = 1'b0;
        #1;
        expect_eq("rst_async", {124'h0, d_cyc, d_gnt}, 128'h0);
        settle(); advance();
        rstn = 1'b1;
        drive(3'b111, 3'b111, 1'b0);
        settle(); advance();
        settle();
        expect_eq("rst_tie", {125'h0, d_gnt}, {125'h0, 3'b001});
        advance();
        drive(3'b000, 3'b000, 1'b0);
        settle(); advance();
        settle(); advance();

        // Hung slave: watchdog fires at the TO-th stalled strobe when enabled
        drive(3'b110, 3'b010, 1'b0);
        settle(); advance();
        for (int k = 1; k <= TO; k++) begin
            settle();
`ifdef WB_ARB_TIMEOUT_EN
            expect_eq("hang_wait", {124'h0, d_err, d_cyc}, (k == TO) ? {124'h0, 3'b010, 1'b0} : {124'h0, 3'b000, 1'b1});
`else
            expect_eq("hang_wait", {124'h0, d_err, d_cyc}, {124'h0, 3'b000, 1'b1});
`endif
            advance();
        end
        drive(3'b110, 3'b010, 1'b1);
        settle();
`ifdef WB_ARB_TIMEOUT_EN
        expect_eq("hang_after", {118'h0, d_ack, d_err, d_cyc, d_gnt}, {118'h0, 3'b000, 3'b000, 1'b0, 3'b010});
`else
        expect_eq("hang_after", {118'h0, d_ack, d_err, d_cyc, d_gnt}, {118'h0, 3'b010, 3'b000, 1'b1, 3'b010});
`endif
        advance();
        drive(3'b100, 3'b100, 1'b0);
        settle(); advance();
        settle(); advance();
        settle();
        expect_eq("hang_next", {125'h0, d_gnt}, {125'h0, 3'b100});
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_cyc[i]) m_cyc[i] = ($urandom_range(0, 2) == 0);
                else           m_cyc[i] = ($urandom_range(0, 3) != 0);
                m_stb[i]          = m_cyc[i] & 1'($urandom_range(0, 1));
                m_we[i]           = 1'($urandom_range(0, 1));
                m_sel[i*4 +: 4]   = 4'($urandom);
                m_adr[i*AW +: AW] = $urandom;
                m_dat[i*DW +: DW] = $urandom;
            end
            s_ack = ($urandom_range(0, 2) == 0);
            s_err = !s_ack && ($urandom_range(0, 9) == 0);
            s_dat = $urandom;
            rstn  = ($urandom_range(0, 199) != 0);
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares one external Wishbone (classic, single-beat) slave port between N cache/LSU masters.
- Default wiring: master 0 = icache, 1 = dcache (wb_bus_c), 2 = LSU (wb_bus_lsu).
- Round-robin arbitration.
- Grant is locked for the whole bus cycle (cyc high), so cache line refills are never interleaved.

Parameters:
- N_MASTERS, 3, number of requesting masters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; sel width = DATA_W/8.
- TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- m_cyc_i  in  N_MASTERS  per-master cycle request.
- m_stb_i  in  N_MASTERS  per-master strobe.
- m_we_i  in  N_MASTERS  per-master write enable.
- m_sel_i  in  N_MASTERS*DATA_W/8  per-master byte selects, flattened, master i at [i*4 +: 4].
- m_adr_i  in  N_MASTERS*ADDR_W  per-master address, flattened.
- m_dat_i  in  N_MASTERS*DATA_W  per-master write data, flattened.
- m_dat_o  out  DATA_W  read data, broadcast to all masters.
- m_ack_o  out  N_MASTERS  per-master ack.
- m_err_o  out  N_MASTERS  per-master error.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_sel_o  out  DATA_W/8  slave byte selects.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave error.
- gnt_o  out  N_MASTERS  one-hot current grant (debug/perf visibility).

Behaviour:
- Reset (async): state=IDLE, gnt_q=0, rr_ptr=0. All s_* outputs 0, m_ack_o=0, m_err_o=0, gnt_o=0, m_dat_o=0.
- FSM states:
  - IDLE: no owner. If any m_cyc_i is set, pick the first requester scanning rr_ptr, rr_ptr+1, … mod N_MASTERS. Register it into gnt_q and go to BUSY. Arbitration latency is 1 cycle: request in cycle k, slave sees s_cyc_o in k+1.
  - BUSY: s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o are combinationally muxed from the granted master. s_ack_i/s_err_i are routed only to the granted master's m_ack_o/m_err_o; the other masters see 0.
  - BUSY exit: when the granted master's m_cyc_i is low, s_cyc_o drops combinationally the same cycle. Next state is IDLE, rr_ptr = granted index+1 mod N_MASTERS, gnt_q=0.
- Multi-beat cycles (cyc held, stb toggled): the grant is kept; other requesters wait.
- Ack and cyc drop in the same cycle: the ack is delivered, then the grant is released. No extra beat is issued.
- Master deasserts cyc before ack: the transfer is abandoned. s_cyc_o is 0 that cycle. A late s_ack_i in IDLE is ignored, with no ack to any master.
- Slave error: s_err_i is forwarded like ack. The grant is held until the master drops cyc.
- Simultaneous requests: strict round-robin. A master cannot win twice in a row while another is requesting.
- In IDLE no s_* output is active; the s_adr/dat/sel outputs are 0.
- Reset mid-cycle: s_cyc_o drops asynchronously. Masters must re-issue.
- m_dat_o = s_dat_i when BUSY, else 0.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- With the macro:
  - a counter runs while BUSY with stb high and no ack/err, reset on every ack/err;
  - when it reaches TIMEOUT, m_err_o of the owner pulses 1 cycle, s_cyc_o is forced low, and the FSM goes to a FLUSH state;
  - FLUSH waits until the owner drops cyc, then goes to IDLE;
  - s_ack_i/s_err_i are ignored in FLUSH.
- Without the macro: no counter, no FLUSH state; a hung slave stalls the bus indefinitely.

Decomposition:
- Package wb_arb_pkg:
  - state enum arb_state_e {IDLE, BUSY, FLUSH};
  - the default master index constants MST_ICACHE=0, MST_DCACHE=1, MST_LSU=2.
- Sub-module rr_picker, combinational: inputs req[N], ptr; outputs one-hot gnt and index. It is unit-testable in isolation.

Test Plan:
- Single master: m1 issues a read at 0x100, slave acks 2 cycles later with 0xDEADBEEF → s_cyc_o rises 1 cycle after m_cyc_i[1]; m_ack_o[1]=1 with m_dat_o=0xDEADBEEF; m_ack_o[0]=m_ack_o[2]=0.
- Contention: m0, m1, m2 all request from reset and each holds cyc for 1 beat → grants are served in order 0,1,2. If m0 re-requests immediately, the order is 0,1,2,0.
- Burst lock: m1 holds cyc for 8 stb/ack beats while m2 requests → gnt_o stays 3'b010 for all 8 acks; m2 is granted the cycle after m1 drops cyc.
- Abort: m2 drops cyc before ack and the slave acks one cycle later → no m_ack_o asserted; FSM in IDLE.
- Reset mid-transfer: rstn_i low while BUSY → s_cyc_o=0 and gnt_o=0 immediately; after release, rr_ptr=0 and m0 wins a 3-way tie.
- With WB_ARB_TIMEOUT_EN and TIMEOUT=16: the slave never acks → m_err_o of the owner pulses at cycle 16 of stb, s_cyc_o=0. After the owner drops cyc, the next requester is granted.
